// File: rtl/calc1_pkg.sv
// Shared types and constants for the calc1 port driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc1_pkg;

  // calc1 command encodings
  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_ADD = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_SHL = 4'b0101;
  localparam logic [3:0] CMD_SHR = 4'b0110;

  // calc1 response encodings
  localparam logic [1:0] RSP_NONE = 2'b00;
  localparam logic [1:0] RSP_OK   = 2'b01;
  localparam logic [1:0] RSP_ERR  = 2'b10;

  // One whole operation as queued in the request FIFO
  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
  } calc1_req_t;

  // Port sequencing states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_OP2  = 3'd2,
    ST_WAIT = 3'd3,
    ST_RESP = 3'd4
  } drv_state_t;

endpackage

// File: rtl/calc1_req_fifo.sv
// Synchronous FIFO of calc1 requests with wrap-bit pointers and a registered count.
// Latency: a pushed entry is visible on pop_dat the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
module calc1_req_fifo
  import calc1_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_vld,
  input  calc1_req_t    push_dat,
  input  logic          pop_vld,
  output calc1_req_t    pop_dat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q,  count_d;
  calc1_req_t  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign count   = count_q;
  assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push_vld && !full;
  assign do_pop  = pop_vld && !empty;

  // Next pointer and occupancy values
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Pointer/count state; storage is flushed logically by the pointer reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at the current write index
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end
  end

endmodule

// File: rtl/calc1_port_driver.sv
// Buffers calc1 operations and sequences them onto one calc1 port (CMD, OP2, WAIT, RESP); CALC1_DRV_TIMEOUT_EN adds a WAIT timeout.
// Latency: accept to CMD cycle is 2 edges; calc1 response to rsp_valid is 1 edge; handshake to next CMD is 2 edges.
// Backpressure: in_ready drops when the FIFO is full; rsp_* hold in RESP until rsp_ready, stalling the port.
module calc1_port_driver
  import calc1_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cmd,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  input  logic [1:0]  calc_resp,
  input  logic [31:0] calc_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_code,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  drv_state_t  state_q, state_d;
  logic [31:0] op2_q, op2_d;
  logic [3:0]  req_cmd_q, req_cmd_d;
  logic [31:0] req_data_q, req_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_code_q, rsp_code_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        busy_q, busy_d;

  calc1_req_t  fifo_in, fifo_out;
  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [AW:0] fifo_count, fifo_count_nxt;

  // Held low in reset so nothing is accepted while the driver is being cleared
  assign in_ready  = reset && !fifo_full;
  // NOP requests complete at the handshake without touching the FIFO
  assign fifo_push = in_valid && in_ready && (in_cmd != CMD_NOP);
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
  assign fifo_in   = '{cmd: in_cmd, op1: in_op1, op2: in_op2};

  calc1_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (c_clk),
    .rst_n    (reset),
    .push_vld (fifo_push),
    .push_dat (fifo_in),
    .pop_vld  (fifo_pop),
    .pop_dat  (fifo_out),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign fifo_count_nxt = fifo_count + (AW+1)'(fifo_push) - (AW+1)'(fifo_pop);

`ifdef CALC1_DRV_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  // Sequencer: port outputs are computed for the state being entered so they are registered
  always_comb begin
    state_d    = state_q;
    op2_d      = op2_q;
    req_cmd_d  = CMD_NOP;
    req_data_d = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_code_d = rsp_code_q;
    rsp_data_d = rsp_data_q;
`ifdef CALC1_DRV_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d    = ST_CMD;
          op2_d      = fifo_out.op2;
          req_cmd_d  = fifo_out.cmd;
          req_data_d = fifo_out.op1;
        end
      end
      ST_CMD: begin
        state_d    = ST_OP2;
        req_data_d = op2_q;
      end
      ST_OP2: begin
        state_d = ST_WAIT;
`ifdef CALC1_DRV_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        // A real response takes priority over a timeout in the same cycle
        if (calc_resp != RSP_NONE) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_code_d  = calc_resp;
          rsp_data_d  = calc_data;
`ifdef CALC1_DRV_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
        end
`ifdef CALC1_DRV_TIMEOUT_EN
        else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d       = ST_RESP;
          rsp_valid_d   = 1'b1;
          rsp_code_d    = RSP_NONE;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE) || (fifo_count_nxt != '0);
  end

  // Driver state and registered outputs
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op2_q       <= '0;
      req_cmd_q   <= CMD_NOP;
      req_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_code_q  <= RSP_NONE;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
`ifdef CALC1_DRV_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op2_q       <= op2_d;
      req_cmd_q   <= req_cmd_d;
      req_data_q  <= req_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_code_q  <= rsp_code_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
`ifdef CALC1_DRV_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign req_cmd_out  = req_cmd_q;
  assign req_data_out = req_data_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_code     = rsp_code_q;
  assign rsp_data     = rsp_data_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_calc1_port_driver.sv
// Directed bench for calc1_port_driver with a small calc1 port model.
// Latency: model answers a fixed number of cycles into WAIT unless silenced.
// Backpressure: rsp_ready is driven by the directed sequences.
module tb_calc1_port_driver;
  import calc1_pkg::*;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_cmd = '0;
  logic [31:0] in_op1 = '0;
  logic [31:0] in_op2 = '0;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  calc_resp = '0;
  logic [31:0] calc_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_code;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic        busy;

  int checks = 0;
  int errors = 0;

  calc1_port_driver dut (
    .c_clk(c_clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_op1(in_op1), .in_op2(in_op2),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
    .calc_resp(calc_resp), .calc_data(calc_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_code(rsp_code), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 c_clk = ~c_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- calc1 port model ----------------
  int          m_ph = 0;
  int          m_cnt = 0;
  int          m_lat = 3;
  bit          m_silent = 1'b0;
  logic [3:0]  m_cmd;
  logic [31:0] m_op1, m_op2;
  logic [32:0] m_tmp;
  int          m_inj_req = 0;
  int          m_inj_done = 0;
  logic [1:0]  m_inj_code = '0;
  logic [31:0] m_inj_data = '0;

  always @(posedge c_clk) begin
    #1;
    calc_resp = RSP_NONE;
    calc_data = '0;
    if (!reset) begin
      m_ph = 0;
    end else if (req_cmd_out != CMD_NOP) begin
      m_cmd = req_cmd_out;
      m_op1 = req_data_out;
      m_ph  = 1;
    end else if (m_ph == 1) begin
      m_op2 = req_data_out;
      m_ph  = 2;
      m_cnt = 0;
    end else if (m_ph == 2) begin
      m_cnt++;
      if (m_cnt == m_lat && !m_silent) begin
        m_ph = 0;
        case (m_cmd)
          CMD_ADD: begin
            m_tmp = {1'b0, m_op1} + {1'b0, m_op2};
            if (m_tmp[32]) begin calc_resp = RSP_ERR; calc_data = '0; end
            else begin calc_resp = RSP_OK; calc_data = m_tmp[31:0]; end
          end
          CMD_SUB: begin
            if (m_op2 > m_op1) begin calc_resp = RSP_ERR; calc_data = '0; end
            else begin calc_resp = RSP_OK; calc_data = m_op1 - m_op2; end
          end
          CMD_SHL: begin calc_resp = RSP_OK; calc_data = m_op1 << m_op2[4:0]; end
          CMD_SHR: begin calc_resp = RSP_OK; calc_data = m_op1 >> m_op2[4:0]; end
          default: begin calc_resp = RSP_ERR; calc_data = '0; end
        endcase
      end
    end
    if (m_inj_req != m_inj_done) begin
      calc_resp = m_inj_code;
      calc_data = m_inj_data;
      m_inj_done++;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic push(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    bit ok = 1'b0;
    in_cmd = c; in_op1 = a; in_op2 = b; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (in_ready) begin ok = 1'b1; tick(); break; end
      tick();
    end
    in_valid = 1'b0;
    chk("push_accepted", ok, 1'b1);
  endtask

  task automatic wait_rsp(input string tag, input logic [1:0] code, input logic [31:0] data,
                          input logic tmo);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      tick();
    end
    chk({tag, "_seen"}, ok, 1'b1);
    if (ok) begin
      chk({tag, "_code"}, rsp_code, code);
      chk({tag, "_data"}, rsp_data, data);
      chk({tag, "_timeout"}, rsp_timeout, tmo);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({tag, "_drop"}, rsp_valid, 1'b0);
    end
  endtask

  task automatic inject(input logic [1:0] code, input logic [31:0] data);
    m_inj_code = code;
    m_inj_data = data;
    m_inj_req++;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit saw_cmd, saw_rsp, ok;

    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_req_cmd", req_cmd_out, 4'h0);
    chk("rst_req_data", req_data_out, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_code", rsp_code, 2'b00);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_timeout", rsp_timeout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b1;
    tick();
    chk("rel_in_ready", in_ready, 1'b1);

    // ADD 5+5 with exact cycle positions
    in_cmd = CMD_ADD; in_op1 = 32'd5; in_op2 = 32'd5; in_valid = 1'b1;
    tick();                                   // edge A accepted
    in_valid = 1'b0;
    chk("add_busy", busy, 1'b1);
    tick();
    chk("add_cmd_phase_cmd", req_cmd_out, 4'b0001);
    chk("add_cmd_phase_data", req_data_out, 32'd5);
    tick();
    chk("add_op2_phase_cmd", req_cmd_out, 4'b0000);
    chk("add_op2_phase_data", req_data_out, 32'd5);
    tick();
    chk("add_wait_cmd", req_cmd_out, 4'b0000);
    chk("add_wait_data", req_data_out, 32'd0);
    tick();
    tick();
    chk("add_not_yet_valid", rsp_valid, 1'b0);
    tick();
    chk("add_valid_edge", rsp_valid, 1'b1);
    wait_rsp("add", RSP_OK, 32'd10, 1'b0);
    chk("add_idle_busy", busy, 1'b0);

    // Five requests with the response side stalled
    for (int k = 1; k <= 5; k++) push(CMD_ADD, 32'(k), 32'(k));
    chk("stall_full", in_ready, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      tick();
    end
    chk("stall_parked", ok, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", rsp_valid, 1'b1);
      chk("stall_code", rsp_code, RSP_OK);
      chk("stall_data", rsp_data, 32'd2);
      chk("stall_port_idle", req_cmd_out, 4'h0);
    end
    chk("stall_still_full", in_ready, 1'b0);
    wait_rsp("drain1", RSP_OK, 32'd2, 1'b0);
    wait_rsp("drain2", RSP_OK, 32'd4, 1'b0);
    wait_rsp("drain3", RSP_OK, 32'd6, 1'b0);
    wait_rsp("drain4", RSP_OK, 32'd8, 1'b0);
    wait_rsp("drain5", RSP_OK, 32'd10, 1'b0);

    // Error response, dropped NOP, unknown command
    push(CMD_SUB, 32'd5, 32'd6);
    push(CMD_NOP, 32'd9, 32'd9);
    push(CMD_ADD, 32'd7, 32'd8);
    push(4'hF, 32'd1, 32'd1);
    wait_rsp("sub_err", RSP_ERR, 32'd0, 1'b0);
    wait_rsp("add15", RSP_OK, 32'd15, 1'b0);
    wait_rsp("bad_cmd", RSP_ERR, 32'd0, 1'b0);
    push(CMD_SHL, 32'd3, 32'd4);
    wait_rsp("shl", RSP_OK, 32'd48, 1'b0);
    saw_rsp = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid) saw_rsp = 1'b1;
    end
    chk("nop_no_response", saw_rsp, 1'b0);
    chk("nop_idle_busy", busy, 1'b0);

    // Silent calc1
    m_silent = 1'b1;
`ifdef CALC1_DRV_TIMEOUT_EN
    in_cmd = CMD_ADD; in_op1 = 32'd1; in_op2 = 32'd2; in_valid = 1'b1;
    tick();                                   // edge A accepted
    in_valid = 1'b0;
    repeat (102) tick();
    chk("tmo_not_yet", rsp_valid, 1'b0);
    tick();
    chk("tmo_valid", rsp_valid, 1'b1);
    chk("tmo_code", rsp_code, RSP_NONE);
    chk("tmo_data", rsp_data, 32'd0);
    chk("tmo_flag", rsp_timeout, 1'b1);
    tick();
    tick();
    inject(RSP_OK, 32'd77);
    tick();
    tick();
    chk("tmo_late_code", rsp_code, RSP_NONE);
    chk("tmo_late_data", rsp_data, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    inject(RSP_OK, 32'd77);
    repeat (5) tick();
    chk("tmo_late_ignored", rsp_valid, 1'b0);
    chk("tmo_idle_busy", busy, 1'b0);
`else
    push(CMD_ADD, 32'd1, 32'd2);
    repeat (150) tick();
    chk("silent_no_rsp", rsp_valid, 1'b0);
    chk("silent_busy", busy, 1'b1);
    inject(RSP_OK, 32'd3);
    wait_rsp("silent_late", RSP_OK, 32'd3, 1'b0);
`endif

    // Reset in WAIT with two requests queued
    push(CMD_ADD, 32'd1, 32'd1);
    push(CMD_ADD, 32'd2, 32'd2);
    push(CMD_ADD, 32'd3, 32'd3);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_req_cmd", req_cmd_out, 4'h0);
    chk("mid_rst_req_data", req_data_out, 32'h0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_rsp_code", rsp_code, 2'b00);
    chk("mid_rst_rsp_data", rsp_data, 32'h0);
    chk("mid_rst_rsp_timeout", rsp_timeout, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    reset = 1'b1;
    m_silent = 1'b0;
    tick();
    chk("mid_rel_in_ready", in_ready, 1'b1);
    saw_cmd = 1'b0;
    saw_rsp = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (req_cmd_out != 4'h0) saw_cmd = 1'b1;
      if (rsp_valid) saw_rsp = 1'b1;
      tick();
    end
    chk("mid_rel_no_cmd", saw_cmd, 1'b0);
    chk("mid_rel_no_rsp", saw_rsp, 1'b0);
    chk("mid_rel_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc1_port_driver.md
# calc1_port_driver

Request sequencer that sits directly upstream of one `calc1_top` request port. It accepts whole operations (command plus two operands) on a valid/ready interface and buffers them in a small FIFO. It drives them onto the calc1 two-cycle port protocol, waits for the calc1 response, and returns the result on a valid/ready response interface. One instance serves one calc1 port (`reqN_*` / `out_respN` / `out_dataN`), and only one operation is outstanding at a time.

## Interface
- `FIFO_DEPTH`, 4: request FIFO entries; power of 2, ≥2.
- `TIMEOUT_CYCLES`, 100: WAIT cycles without response before timeout; ≥1.

- `c_clk` in 1: clock.
- `reset` in 1: one clock; reset is synchronous and active-low.
- `in_valid` in 1: request valid.
- `in_ready` out 1: FIFO can accept.
- `in_cmd` in [0:3]: calc1 command.
- `in_op1`, `in_op2` in [0:31]: operands.
- `req_cmd_out` out [0:3]: to calc1 `reqN_cmd_in`.
- `req_data_out` out [0:31]: to calc1 `reqN_data_in`.
- `calc_resp` in [0:1]: from calc1 `out_respN`.
- `calc_data` in [0:31]: from calc1 `out_dataN`.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_code` out [0:1]: 01 success, 10 overflow/underflow/invalid, 00 on timeout.
- `rsp_data` out [0:31]: result.
- `rsp_timeout` out 1: response produced by timeout.
- `busy` out 1: FSM not IDLE or FIFO not empty.

## Operation
- Accept on `in_valid & in_ready`. `in_cmd == 0000` is accepted and dropped: no FIFO write, no response. Every other command is forwarded unchecked; calc1 flags invalid ones with 10.
- `in_ready = !full`, computed from the registered count. There is no bypass. A pop and a push in the same cycle are both legal when the FIFO is not full.
- FSM states: IDLE → CMD → OP2 → WAIT → RESP → IDLE.
  - IDLE: if the FIFO is non-empty, pop and go to CMD.
  - CMD: `req_cmd_out = cmd`, `req_data_out = op1`.
  - OP2: `req_cmd_out = 0000`, `req_data_out = op2`.
  - WAIT: `req_cmd_out = 0000`, `req_data_out = 0`. When `calc_resp != 00`, capture `calc_resp` and `calc_data` and go to RESP.
  - RESP: `rsp_valid = 1`; `rsp_*` held stable until `rsp_ready`, then go to IDLE.
- `calc_resp != 00` sampled outside WAIT, including late responses after a timeout, is ignored.
- Reset applied mid-operation: FIFO flushed, FSM to IDLE, in-flight operation abandoned with no response.
- Reset values: `in_ready` 0 while `reset` is low, 1 from the first cycle after release. `req_cmd_out` 0000, `req_data_out` 0, `rsp_valid` 0, `rsp_code` 00, `rsp_data` 0, `rsp_timeout` 0, `busy` 0.

## Timing
- All outputs are registered except `in_ready`, which comes from the count register.
- Accept edge A with an empty FIFO and the FSM in IDLE:
  - CMD cycle follows edge A+1.
  - OP2 cycle follows edge A+2.
  - WAIT begins after edge A+3.
- `calc_resp` is sampled nonzero at edge R; `rsp_valid` is high in the cycle after R.
- Response handshake at edge H; the next CMD cycle follows edge H+1 at the earliest.
- Back-to-back operations therefore cost 3 + calc1 latency + 2 cycles minimum.

## Configuration
- `CALC1_DRV_TIMEOUT_EN` defined:
  - An 8-bit-minimum counter, sized `$clog2(TIMEOUT_CYCLES+1)`, clears on WAIT entry and increments each WAIT cycle with `calc_resp == 00`.
  - On reaching `TIMEOUT_CYCLES`, go to RESP with `rsp_code = 00`, `rsp_data = 0`, `rsp_timeout = 1`.
  - A response and a timeout in the same cycle: the response wins.
- Not defined: WAIT persists indefinitely, no counter is built, and `rsp_timeout` is tied to 0.

## Structure
- Package `calc1_pkg`:
  - Command constants: NOP 0000, ADD 0001, SUB 0010, SHL 0101, SHR 0110.
  - Response constants: NONE 00, OK 01, ERR 10.
  - Request struct {cmd, op1, op2}.
  - FSM state enum.
- Sub-module `calc1_req_fifo`: synchronous FIFO of the request struct, pointers of `$clog2(FIFO_DEPTH)` bits plus a wrap bit, with full/empty/count outputs.

## Test plan
- ADD op1 = 5, op2 = 5, calc1 model answers 01/10 three cycles into WAIT:
  - `req_cmd_out`/`req_data_out` show 0001/5, then 0000/5.
  - Response is `rsp_code` 01, `rsp_data` 10, `rsp_timeout` 0.
- Push 5 requests with `rsp_ready = 0`:
  - Operation 1 is popped and parked in RESP, and `in_ready` drops once FIFO_DEPTH more requests are queued.
  - Releasing `rsp_ready` drains all operations in FIFO order with the correct data.
- SUB 5 − 6, model returns 10 → `rsp_code` 10, stall and ordering unaffected. A request with `in_cmd` 0000 produces no response.
- Macro defined, model silent → `rsp_valid` in the cycle after the 100th WAIT cycle, code 00, `rsp_timeout` 1. A model response 3 cycles later is ignored.
- `reset` low during WAIT with 2 queued requests → all outputs at reset values the next cycle. After release, no response and no command is issued.
- `rsp_ready` held low for 10 cycles in RESP → `rsp_*` stable and `req_cmd_out` stays 0000 throughout.
